// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming (SECDED) encoder/decoder family:
// position-map helpers and the error classification enum.
package hamming_pkg;

  typedef enum logic [1:0] {CLEAN, CORR, UNCORR} err_class_t;

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic int par_bits_for(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // Data bit index carried at a non-parity position: count data slots below it.
  function automatic int data_idx(input int pos);
    int idx;
    idx = 0;
    for (int k = 1; k < pos; k++) begin
      if (!is_pow2(k)) idx++;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended-Hamming codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int PAR_W  = 3
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [PAR_W-1:0]  syndrome_o,
  output logic              ovp_o
);

  always_comb begin
    syndrome_o = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (code_i[pos]) syndrome_o = syndrome_o ^ PAR_W'(pos);
    end
  end

  assign ovp_o = ^code_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder on a valid/ready stream, with saturating
// corrected/uncorrectable word counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 8,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [PAR_W-1:0]  err_pos,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr,
  input  logic              cnt_clr
);

  if ((1 << PAR_W) < CODE_W) begin : g_bad_par_w
    $error("PAR_W too small: 2**PAR_W must be >= DATA_W+PAR_W+1");
  end

  logic [PAR_W-1:0] syn_c;
  logic             ovp_c;

  hamming_syndrome #(.CODE_W(CODE_W), .PAR_W(PAR_W)) u_syndrome (
    .code_i     (code_in),
    .syndrome_o (syn_c),
    .ovp_o      (ovp_c)
  );

  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_ovp_q;
  logic              s2_valid_q;
  logic [DATA_W-1:0] data_q;
  logic              corr_q, uncorr_q;
  logic [PAR_W-1:0]  pos_q;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;

  logic s1_load, s2_load, out_hs;
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = s2_valid_q && out_ready;

  err_class_t        cls_d;
  logic [CODE_W-1:0] fixed_d;
  logic [DATA_W-1:0] data_d;

  // A syndrome beyond the last position with odd overall parity cannot be a single flip.
  always_comb begin
    cls_d   = CLEAN;
    fixed_d = s1_code_q;
    if (s1_ovp_q) begin
      if (32'(s1_syn_q) < CODE_W) begin
        cls_d   = CORR;
        fixed_d = s1_code_q ^ (CODE_W'(1) << s1_syn_q);
      end else begin
        cls_d = UNCORR;
      end
    end else if (s1_syn_q != '0) begin
      cls_d = UNCORR;
    end
  end

  for (genvar gi = 1; gi < CODE_W; gi++) begin : g_extract
    if (!is_pow2(gi)) begin : g_data
      assign data_d[data_idx(gi)] = fixed_d[gi];
    end
  end

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_hs) begin
      if (corr_q && cnt_corr_q != '1)     cnt_corr_d   = cnt_corr_q + CNT_W'(1);
      if (uncorr_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_ovp_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      data_q       <= '0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      pos_q        <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_code_q <= code_in;
          s1_syn_q  <= syn_c;
          s1_ovp_q  <= ovp_c;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          data_q   <= data_d;
          corr_q   <= (cls_d == CORR);
          uncorr_q <= (cls_d == UNCORR);
          pos_q    <= s1_syn_q;
        end
      end
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign data_out   = data_q;
  assign err_corr   = corr_q;
  assign err_uncorr = uncorr_q;
  assign err_pos    = pos_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule
